settings_selector: RTL and testbench
====================================

# settings_selector

Parametrised pre-game settings selector for the Flood-It design. It holds NUM_FIELDS independent wrap-around setting fields, such as colour count and board size. The player moves a cursor between fields with LEFT/RIGHT and steps the selected field with UP/DOWN, with auto-repeat while held. CENTER freezes the values and starts the game through a req/ack handshake with the game core; the block then stays locked until the game ends or is aborted.

## Interface
Parameters:
- NUM_FIELDS, 2, number of setting fields (≥1)
- FIELD_W, 5, bits per field value
- FIELD_MIN, {5'd2,5'd3}, packed NUM_FIELDS*FIELD_W lower bounds; field i at [i*FIELD_W +: FIELD_W]
- FIELD_MAX, {5'd26,5'd8}, packed upper bounds
- FIELD_STEP, {5'd4,5'd1}, packed step sizes (≥1)
- FIELD_INIT, {5'd14,5'd6}, packed reset values; must lie in [MIN,MAX]
- REPEAT_DELAY, 50_000_000, hold cycles before the first auto-repeat
- REPEAT_PERIOD, 10_000_000, cycles between subsequent auto-repeats
- CUR_W, max(1,$clog2(NUM_FIELDS)), cursor width (derived)

Ports:
- MASTER_CLOCK  in  1  system clock; the only clock
- RESET  in  1  asynchronous, active-high reset
- UP, DOWN, LEFT, RIGHT, CENTER  in  1 each  debounced buttons, asynchronous to MASTER_CLOCK
- ACK_BEGIN_GAME  in  1  game core has accepted the frozen settings
- GAME_DONE  in  1  one-cycle pulse: game finished
- FIELD_VALUES  out  NUM_FIELDS*FIELD_W  live (editable) values
- FINAL_VALUES  out  NUM_FIELDS*FIELD_W  values frozen at CENTER
- CURSOR  out  CUR_W  index of the selected field
- BEGIN_GAME  out  1  start request
- MODE  out  1  high in REQ and PLAY (selection locked)
- ABORT  out  1  one-cycle pulse: player aborted the game

## Operation
- Each button passes through a 2-flop synchroniser and then a delay flop. The press event is sync & ~delay. All synchroniser and delay flops reset to 0.
- One action per cycle, in priority CENTER > LEFT/RIGHT > UP/DOWN. Lower-priority events in the same cycle are dropped.
- If LEFT and RIGHT, or UP and DOWN, press in the same cycle, that pair is ignored.
- State EDIT (reset state):
  - LEFT: CURSOR−1, wrapping 0 → NUM_FIELDS−1.
  - RIGHT: CURSOR+1, wrapping NUM_FIELDS−1 → 0.
  - UP: v = v+STEP. If the result exceeds MAX, v = MIN.
  - DOWN: v = v−STEP. If v < MIN+STEP, v = MAX.
  - The comparisons above use FIELD_W+1-bit arithmetic, so there is no overflow.
  - Only field CURSOR changes; all other fields hold.
  - CENTER: FINAL_VALUES ← FIELD_VALUES, BEGIN_GAME ← 1, go to REQ.
- Auto-repeat (EDIT only):
  - An UP or DOWN press event clears the hold counter.
  - While exactly one of UP/DOWN stays synchronised-high, the counter runs.
  - At count REPEAT_DELAY a repeat step is issued, then another every REPEAT_PERIOD cycles.
  - Releasing the button, or any other action, clears the counter.
  - The counter saturates and never wraps.
- State REQ:
  - BEGIN_GAME held at 1 until ACK_BEGIN_GAME is sampled high.
  - Then BEGIN_GAME ← 0 and go to PLAY.
  - All buttons are ignored.
- State PLAY:
  - GAME_DONE → EDIT.
  - A CENTER press event → ABORT pulse for one cycle, then EDIT.
  - If GAME_DONE and a CENTER press coincide, GAME_DONE wins: EDIT, no ABORT.
  - Other buttons are ignored.
- FIELD_VALUES and CURSOR keep their values across a game. FINAL_VALUES changes only on the EDIT→REQ transition.

## Timing
- Reset values:
  - FIELD_VALUES = FINAL_VALUES = FIELD_INIT
  - CURSOR = 0, BEGIN_GAME = 0, MODE = 0, ABORT = 0
  - state EDIT, hold counter 0
- Asserting RESET mid-operation clears all of the above immediately, including dropping BEGIN_GAME in REQ.
- A button held through reset release yields one press event after synchronisation.
- Button latency: if a button is first sampled high at edge N, the resulting register update is visible after edge N+2.
- Handshake:
  - BEGIN_GAME rises one edge after the CENTER press event.
  - ACK sampled high at edge K → BEGIN_GAME low and MODE still 1 after edge K.
  - An ACK that is already high on REQ entry completes on the first REQ cycle.
- MODE is registered: 1 from the EDIT→REQ edge until the PLAY→EDIT edge.
- ABORT is registered and high for exactly one cycle, coincident with MODE falling.
- Auto-repeat: with the press event at cycle 0, repeats land at cycles REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, and so on. Measured at the field register, each is one cycle after the counter hits its threshold.

## Test plan
- Reset with defaults → FIELD_VALUES = {14,6}, CURSOR = 0. Then UP ×3 → field0 = 7, 8, 3. Then DOWN → 8.
- RIGHT, then UP ×3 from 14 → field1 = 18, 22, 26. UP → 2. DOWN → 26. RIGHT again → CURSOR wraps to 0.
- REPEAT_DELAY = 20, REPEAT_PERIOD = 5, hold UP on field0 (value 6) for 35 cycles → exactly 4 increments, 6→7→8→3→4. Release → no further change.
- CENTER → BEGIN_GAME and MODE = 1, FINAL_VALUES = FIELD_VALUES. Hold ACK low 10 cycles → BEGIN_GAME stays 1 and UP is ignored. ACK high → BEGIN_GAME low next edge, MODE = 1.
- In PLAY, pulse GAME_DONE and press CENTER in the same cycle → MODE = 0, ABORT never asserted. Next game, CENTER alone → one-cycle ABORT, MODE = 0.
- Assert RESET while in REQ → BEGIN_GAME and MODE 0 immediately, values = FIELD_INIT. UP and DOWN in the same cycle in EDIT → no change.

Source files
------------

// File: rtl/settings_selector.sv
// rtl/settings_selector.sv - pre-game settings selector: wrap-around fields, cursor, auto-repeat, start handshake
module settings_selector #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W = 5,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MIN  = {5'd2, 5'd3},
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX  = {5'd26, 5'd8},
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_STEP = {5'd4, 5'd1},
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_INIT = {5'd14, 5'd6},
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CUR_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic MASTER_CLOCK,
  input  logic RESET,
  input  logic UP,
  input  logic DOWN,
  input  logic LEFT,
  input  logic RIGHT,
  input  logic CENTER,
  input  logic ACK_BEGIN_GAME,
  input  logic GAME_DONE,
  output logic [NUM_FIELDS*FIELD_W-1:0] FIELD_VALUES,
  output logic [NUM_FIELDS*FIELD_W-1:0] FINAL_VALUES,
  output logic [CUR_W-1:0] CURSOR,
  output logic BEGIN_GAME,
  output logic MODE,
  output logic ABORT
);

  localparam int CNT_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(CNT_MAXV + 1);
  localparam logic [CNT_W-1:0] DELAY_TH  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_TH = CNT_W'(REPEAT_PERIOD - 1);
  localparam int B_UP = 0, B_DN = 1, B_L = 2, B_R = 3, B_C = 4;

  typedef enum logic [1:0] {S_EDIT, S_REQ, S_PLAY} state_t;

  state_t state_q, state_n;
  logic [4:0] sync1_q, sync2_q, dly_q, press;
  logic [NUM_FIELDS*FIELD_W-1:0] field_q, field_n, final_q, final_n;
  logic [CUR_W-1:0] cursor_q, cursor_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic repeating_q, repeating_n;
  logic begin_q, begin_n, mode_q, mode_n, abort_q, abort_n;
  logic hold, do_step, step_up;

  function automatic logic [FIELD_W-1:0] step_value(input logic [FIELD_W-1:0] v, mn, mx, st,
                                                    input logic inc);
    logic [FIELD_W:0] sum;
    sum = {1'b0, v} + {1'b0, st};
    if (inc)
      step_value = (sum > {1'b0, mx}) ? mn : sum[FIELD_W-1:0];
    else
      step_value = ({1'b0, v} < ({1'b0, mn} + {1'b0, st})) ? mx : v - st;
  endfunction

  always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
    end else begin
      sync1_q <= {CENTER, RIGHT, LEFT, DOWN, UP};
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign press = sync2_q & ~dly_q;
  assign hold  = sync2_q[B_UP] ^ sync2_q[B_DN];

  always_comb begin
    state_n     = state_q;
    field_n     = field_q;
    final_n     = final_q;
    cursor_n    = cursor_q;
    cnt_n       = '0;
    repeating_n = 1'b0;
    begin_n     = begin_q;
    abort_n     = 1'b0;
    do_step     = 1'b0;
    step_up     = 1'b0;
    case (state_q)
      S_EDIT: begin
        if (press[B_C]) begin
          final_n = field_q;
          begin_n = 1'b1;
          state_n = S_REQ;
        end else if (press[B_L] ^ press[B_R]) begin
          if (press[B_L])
            cursor_n = (cursor_q == '0) ? CUR_W'(NUM_FIELDS - 1) : cursor_q - CUR_W'(1);
          else
            cursor_n = (cursor_q == CUR_W'(NUM_FIELDS - 1)) ? '0 : cursor_q + CUR_W'(1);
        end else if (press[B_UP] ^ press[B_DN]) begin
          do_step = 1'b1;
          step_up = press[B_UP];
        end else if (hold) begin
          // Counter restarts after every repeat; the first gap uses the longer delay.
          if (cnt_q == (repeating_q ? PERIOD_TH : DELAY_TH)) begin
            do_step     = 1'b1;
            step_up     = sync2_q[B_UP];
            repeating_n = 1'b1;
          end else begin
            cnt_n       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            repeating_n = repeating_q;
          end
        end
      end
      S_REQ: begin
        if (ACK_BEGIN_GAME) begin
          begin_n = 1'b0;
          state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (GAME_DONE) begin
          state_n = S_EDIT;
        end else if (press[B_C]) begin
          abort_n = 1'b1;
          state_n = S_EDIT;
        end
      end
      default: state_n = S_EDIT;
    endcase
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (do_step && (CUR_W'(i) == cursor_q))
        field_n[i*FIELD_W +: FIELD_W] = step_value(field_q[i*FIELD_W +: FIELD_W],
                                                   FIELD_MIN[i*FIELD_W +: FIELD_W],
                                                   FIELD_MAX[i*FIELD_W +: FIELD_W],
                                                   FIELD_STEP[i*FIELD_W +: FIELD_W], step_up);
    end
    mode_n = (state_n != S_EDIT);
  end

  always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_EDIT;
      field_q     <= FIELD_INIT;
      final_q     <= FIELD_INIT;
      cursor_q    <= '0;
      cnt_q       <= '0;
      repeating_q <= 1'b0;
      begin_q     <= 1'b0;
      mode_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      field_q     <= field_n;
      final_q     <= final_n;
      cursor_q    <= cursor_n;
      cnt_q       <= cnt_n;
      repeating_q <= repeating_n;
      begin_q     <= begin_n;
      mode_q      <= mode_n;
      abort_q     <= abort_n;
    end
  end

  assign FIELD_VALUES = field_q;
  assign FINAL_VALUES = final_q;
  assign CURSOR       = cursor_q;
  assign BEGIN_GAME   = begin_q;
  assign MODE         = mode_q;
  assign ABORT        = abort_q;

endmodule

// File: tb/tb_settings_selector.sv
// tb/tb_settings_selector.sv - self-checking bench for settings_selector
module tb_settings_selector;
  localparam int NF = 2, FW = 5, RD = 20, RP = 5;
  localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_L = 5'b00100,
                         B_R = 5'b01000, B_C = 5'b10000, B_NONE = 5'b00000;

  logic clk = 1'b0, rst = 1'b1;
  logic up = 0, down = 0, left = 0, right = 0, center = 0, ack = 0, done = 0;
  logic [NF*FW-1:0] field_values, final_values;
  logic cursor, begin_game, mode, abort;

  always #5 clk = ~clk;

  settings_selector #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .MASTER_CLOCK(clk), .RESET(rst), .UP(up), .DOWN(down), .LEFT(left), .RIGHT(right),
    .CENTER(center), .ACK_BEGIN_GAME(ack), .GAME_DONE(done), .FIELD_VALUES(field_values),
    .FINAL_VALUES(final_values), .CURSOR(cursor), .BEGIN_GAME(begin_game), .MODE(mode),
    .ABORT(abort));

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integers, press seen two samples after the button, repeat by elapsed count.
  function automatic int fmin(int i);  return (i == 0) ? 3 : 2;   endfunction
  function automatic int fmax(int i);  return (i == 0) ? 8 : 26;  endfunction
  function automatic int fstep(int i); return (i == 0) ? 1 : 4;   endfunction
  function automatic int finit(int i); return (i == 0) ? 6 : 14;  endfunction

  int m_fv[NF], m_fin[NF];
  int m_cur, m_phase, m_k;
  bit m_begin, m_abort;
  logic [4:0] h0, h1, h2;

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_fv[i] = finit(i);
      m_fin[i] = finit(i);
    end
    m_cur = 0; m_phase = 0; m_k = 0; m_begin = 0; m_abort = 0;
    h0 = '0; h1 = '0; h2 = '0;
  endtask

  task automatic model_step(input bit inc);
    int v;
    v = m_fv[m_cur];
    if (inc) v = (v + fstep(m_cur) > fmax(m_cur)) ? fmin(m_cur) : v + fstep(m_cur);
    else     v = (v < fmin(m_cur) + fstep(m_cur)) ? fmax(m_cur) : v - fstep(m_cur);
    m_fv[m_cur] = v;
  endtask

  task automatic model_edge(input logic [4:0] b, input logic a, input logic d);
    logic [4:0] p;
    p = h1 & ~h2;
    m_abort = 0;
    if (m_phase == 0) begin
      if (p[4]) begin
        for (int i = 0; i < NF; i++) m_fin[i] = m_fv[i];
        m_begin = 1; m_phase = 1; m_k = 0;
      end else if (p[2] != p[3]) begin
        m_cur = p[2] ? (m_cur + NF - 1) % NF : (m_cur + 1) % NF;
        m_k = 0;
      end else if (p[0] != p[1]) begin
        model_step(p[0]);
        m_k = 0;
      end else if (h1[0] != h1[1]) begin
        m_k++;
        if (m_k >= RD && (m_k - RD) % RP == 0) model_step(h1[0]);
      end else m_k = 0;
    end else if (m_phase == 1) begin
      m_k = 0;
      if (a) begin m_begin = 0; m_phase = 2; end
    end else begin
      m_k = 0;
      if (d) m_phase = 0;
      else if (p[4]) begin m_abort = 1; m_phase = 0; end
    end
    h2 = h1; h1 = h0; h0 = b;
  endtask

  function automatic logic [23:0] model_vec();
    return {FW'(m_fv[1]), FW'(m_fv[0]), FW'(m_fin[1]), FW'(m_fin[0]), m_cur[0], m_begin,
            (m_phase != 0), m_abort};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {field_values, final_values, cursor, begin_game, mode, abort};
  endfunction

  task automatic step_cycle(input logic [4:0] b, input logic a, input logic d);
    {center, right, left, down, up} = b;
    ack = a; done = d;
    @(posedge clk);
    model_edge(b, a, d);
    @(negedge clk);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("reset_state", dut_vec(), model_vec());
  endtask

  typedef struct {
    logic [4:0] btn;
    int f0;
    int f1;
    int cur;
  } vec_t;
  vec_t tbl[15];

  int changes, abort_cycles;
  logic [FW-1:0] prev_f0;
  bit abort_seen;

  initial begin
    tbl[0]  = '{B_UP, 7, 14, 0};
    tbl[1]  = '{B_UP, 8, 14, 0};
    tbl[2]  = '{B_UP, 3, 14, 0};
    tbl[3]  = '{B_DN, 8, 14, 0};
    tbl[4]  = '{B_R, 8, 14, 1};
    tbl[5]  = '{B_UP, 8, 18, 1};
    tbl[6]  = '{B_UP, 8, 22, 1};
    tbl[7]  = '{B_UP, 8, 26, 1};
    tbl[8]  = '{B_UP, 8, 2, 1};
    tbl[9]  = '{B_DN, 8, 26, 1};
    tbl[10] = '{B_R, 8, 26, 0};
    tbl[11] = '{B_UP | B_DN, 8, 26, 0};
    tbl[12] = '{B_L, 8, 26, 1};
    tbl[13] = '{B_L, 8, 26, 0};
    tbl[14] = '{B_L | B_R, 8, 26, 0};

    model_reset();
    do_reset();
    check("reset_fields", {32'd0, 22'd0, field_values}, {32'd0, 22'd0, 5'd14, 5'd6});

    for (int i = 0; i < 15; i++) begin
      step_cycle(tbl[i].btn, 0, 0);
      repeat (3) step_cycle(B_NONE, 0, 0);
      check($sformatf("table%0d", i), {field_values, cursor, mode, begin_game},
            {FW'(tbl[i].f1), FW'(tbl[i].f0), tbl[i].cur[0], 1'b0, 1'b0});
    end

    // Auto-repeat: 35 cycles held from 6 gives 7, 8, 3, 4.
    do_reset();
    changes = 0;
    prev_f0 = field_values[FW-1:0];
    for (int i = 0; i < 45; i++) begin
      step_cycle((i < 35) ? B_UP : B_NONE, 0, 0);
      if (field_values[FW-1:0] != prev_f0) changes++;
      prev_f0 = field_values[FW-1:0];
    end
    check("repeat_count", 64'(changes), 64'd4);
    check("repeat_value", 64'(field_values[FW-1:0]), 64'd4);

    // Start request, ACK held off while UP is pressed.
    step_cycle(B_C, 0, 0);
    repeat (2) step_cycle(B_NONE, 0, 0);
    check("req_enter", {final_values, begin_game, mode}, {5'd14, 5'd4, 1'b1, 1'b1});
    step_cycle(B_UP, 0, 0);
    repeat (9) step_cycle(B_NONE, 0, 0);
    check("req_hold", {field_values, begin_game, mode}, {5'd14, 5'd4, 1'b1, 1'b1});
    step_cycle(B_NONE, 1, 0);
    check("ack_done", {begin_game, mode}, 2'b01);

    // GAME_DONE coinciding with a CENTER press event wins.
    abort_seen = 0;
    step_cycle(B_C, 0, 0);
    abort_seen |= abort;
    step_cycle(B_NONE, 0, 0);
    abort_seen |= abort;
    step_cycle(B_NONE, 0, 1);
    abort_seen |= abort;
    for (int i = 0; i < 3; i++) begin
      step_cycle(B_NONE, 0, 0);
      abort_seen |= abort;
    end
    check("done_wins", {abort_seen, mode}, 2'b00);

    // New game, then abort with CENTER alone.
    step_cycle(B_C, 0, 0);
    repeat (2) step_cycle(B_NONE, 0, 0);
    step_cycle(B_NONE, 1, 0);
    check("play_mode", {begin_game, mode}, 2'b01);
    abort_cycles = 0;
    step_cycle(B_C, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step_cycle(B_NONE, 0, 0);
      if (abort) begin
        abort_cycles++;
        check("abort_mode", 64'(mode), 64'd0);
      end
    end
    check("abort_cycles", 64'(abort_cycles), 64'd1);

    // Asynchronous reset while waiting in REQ.
    step_cycle(B_C, 0, 0);
    repeat (2) step_cycle(B_NONE, 0, 0);
    check("req_again", {begin_game, mode}, 2'b11);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_reset", dut_vec(), {5'd14, 5'd6, 5'd14, 5'd6, 4'b0000});
    @(negedge clk);
    rst = 1'b0;

    // Random buttons, ACK and GAME_DONE against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] b;
      b = {center, right, left, down, up};
      if ($urandom_range(5) == 0) b[$urandom_range(4)] ^= 1'b1;
      step_cycle(b, ($urandom_range(3) == 0), ($urandom_range(15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
